// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multi-cycle RV32I control path: the controller
// state enum, the opcode constants the controller decodes, and the select
// encodings driven onto the datapath muxes (ResultSrc, ALUSrcA, ALUSrcB),
// the ALU operation codes and the ImmSrc codes. The immediate extender
// imports the same ImmSrc constants so both sides agree on the format code.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

   // Controller states, one per datapath clock.
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11
   } state_e;

   // ALU operation class handed to the ALU decoder.
   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_e;

   // Opcodes (instr[6:0]).
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ImmSrc codes for the immediate extender.
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALUControl codes.
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ResultSrc codes.
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // ALUSrcA codes.
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;

   // ALUSrcB codes.
   localparam logic [1:0] SRCB_RS2    = 2'b00;
   localparam logic [1:0] SRCB_IMMEXT = 2'b01;
   localparam logic [1:0] SRCB_FOUR   = 2'b10;

   // Immediate format chosen from the opcode alone. jalr shares the I
   // format even though the controller does not execute it.
   function automatic logic [2:0] imm_src_of(input logic [6:0] op);
      logic [2:0] imm;
      case (op)
         OP_LOAD, OP_ITYPE, OP_JALR: imm = IMM_I;
         OP_STORE:                   imm = IMM_S;
         OP_BRANCH:                  imm = IMM_B;
         OP_JAL:                     imm = IMM_J;
         OP_LUI:                     imm = IMM_U;
         default:                    imm = IMM_I;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational ALU operation decode.
//   aluop      in  2  operation class: add, sub, or decode from funct fields
//   funct3     in  3  instr[14:12]
//   funct7b5   in  1  instr[30]
//   op5        in  1  instr[5], 1 for R-type, 0 for I-type ALU
//   alu_control out 3 ALUControl code
// ---------------------------------------------------------------------------
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  aluop_e     aluop,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op5,
   output logic [2:0] alu_control
);

   // Map operation class and funct fields onto an ALU code.
   always_comb begin
      alu_control = ALU_ADD;
      case (aluop)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3)
               // instr[30] is immediate data for addi, so only R-type
               // may select sub.
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Main controller of the multi-cycle RV32I core. Walks the shared datapath
// through fetch, decode and the per-class execute/memory/writeback states,
// one state per clock, and drives every datapath select and enable.
//   clk        in  1  rising-edge clock
//   rst        in  1  synchronous active-high reset
//   op         in  7  instr[6:0]
//   funct3     in  3  instr[14:12]
//   funct7b5   in  1  instr[30]
//   zero       in  1  ALU zero flag
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite      out 1 enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB                       out 2 mux selects
//   ALUControl out 3  ALU operation
//   ImmSrc     out 3  immediate format (decoded from op only)
//   illegal    out 1  one-cycle pulse on an unsupported opcode in decode
// ---------------------------------------------------------------------------
module mc_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter state_e RESET_STATE = S_FETCH
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       RegWrite,
   output logic       illegal
);

   state_e     state_q;
   state_e     state_d;
   aluop_e     aluop_s;
   logic       pc_write_s;
   logic       adr_src_s;
   logic       mem_write_s;
   logic       ir_write_s;
   logic       reg_write_s;
   logic       illegal_s;
   logic [1:0] result_src_s;
   logic [1:0] alu_src_a_s;
   logic [1:0] alu_src_b_s;

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RESET_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-state output decode.
   always_comb begin
      state_d      = S_FETCH;
      aluop_s      = ALUOP_ADD;
      pc_write_s   = 1'b0;
      adr_src_s    = 1'b0;
      mem_write_s  = 1'b0;
      ir_write_s   = 1'b0;
      reg_write_s  = 1'b0;
      illegal_s    = 1'b0;
      result_src_s = RES_ALUOUT;
      alu_src_a_s  = SRCA_PC;
      alu_src_b_s  = SRCB_RS2;

      case (state_q)
         S_FETCH: begin
            // PC+4 goes straight from the ALU into PC.
            ir_write_s   = 1'b1;
            pc_write_s   = 1'b1;
            alu_src_a_s  = SRCA_PC;
            alu_src_b_s  = SRCB_FOUR;
            result_src_s = RES_ALURESULT;
            state_d      = S_DECODE;
         end
         S_DECODE: begin
            // OldPC + ImmExt lands in ALUOut for a later branch/jal.
            alu_src_a_s = SRCA_OLDPC;
            alu_src_b_s = SRCB_IMMEXT;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_LUI:            state_d = S_LUI;
               default: begin
                  illegal_s = 1'b1;
                  state_d   = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a_s = SRCA_RS1;
            alu_src_b_s = SRCB_IMMEXT;
            // Only lw and sw reach here; op[5] separates them.
            state_d     = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src_s    = 1'b1;
            result_src_s = RES_ALUOUT;
            state_d      = S_MEMWB;
         end
         S_MEMWB: begin
            result_src_s = RES_DATA;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src_s    = 1'b1;
            result_src_s = RES_ALUOUT;
            mem_write_s  = 1'b1;
            state_d      = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a_s = SRCA_RS1;
            alu_src_b_s = SRCB_RS2;
            aluop_s     = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a_s = SRCA_RS1;
            alu_src_b_s = SRCB_IMMEXT;
            aluop_s     = ALUOP_FUNCT;
            state_d     = S_ALUWB;
         end
         S_ALUWB: begin
            result_src_s = RES_ALUOUT;
            reg_write_s  = 1'b1;
            state_d      = S_FETCH;
         end
         S_BRANCH: begin
            // rs1 - rs2 sets zero; ALUOut still holds the target for PC.
            alu_src_a_s  = SRCA_RS1;
            alu_src_b_s  = SRCB_RS2;
            aluop_s      = ALUOP_SUB;
            result_src_s = RES_ALUOUT;
            case (funct3)
               3'b000:  pc_write_s = zero;
               3'b001:  pc_write_s = ~zero;
               default: pc_write_s = 1'b0;
            endcase
            state_d = S_FETCH;
         end
         S_JAL: begin
            // Target from ALUOut into PC while OldPC+4 forms the link value.
            alu_src_a_s  = SRCA_OLDPC;
            alu_src_b_s  = SRCB_FOUR;
            result_src_s = RES_ALUOUT;
            pc_write_s   = 1'b1;
            state_d      = S_ALUWB;
         end
         S_LUI: begin
            // 0 + U-immediate.
            alu_src_a_s = SRCA_ZERO;
            alu_src_b_s = SRCB_IMMEXT;
            state_d     = S_ALUWB;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   alu_decoder u_alu_decoder (
      .aluop       (aluop_s),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (ALUControl)
   );

   // Architectural side effects are suppressed for as long as rst is held,
   // even before the state register has been forced to fetch.
   assign PCWrite   = pc_write_s  & ~rst;
   assign MemWrite  = mem_write_s & ~rst;
   assign IRWrite   = ir_write_s  & ~rst;
   assign RegWrite  = reg_write_s & ~rst;
   assign illegal   = illegal_s   & ~rst;
   assign AdrSrc    = adr_src_s;
   assign ResultSrc = result_src_s;
   assign ALUSrcA   = alu_src_a_s;
   assign ALUSrcB   = alu_src_b_s;
   assign ImmSrc    = imm_src_of(op);

endmodule
